collision_manager: RTL and testbench
====================================

COLLISION_MANAGER -- requirements
Module: collision_manager

Interface
REQ-001 Parameter NUM_OBSTACLES, default 10: number of obstacle slots examined per cycle.
REQ-002 Parameter START_LIVES, default 3: lives loaded at reset and on restart.
REQ-003 Parameter MAX_LIVES, default 5: saturation ceiling for lives.
REQ-004 Parameter INVULN_FRAMES, default 120: length of the invulnerability window after a hit, in frame_tick pulses.
REQ-005 Port system_clock_in, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port obstacles, input, obstacle [NUM_OBSTACLES-1:0]: obstacle slots (active, lane, sprite_type, position).
REQ-008 Port lane, input, 2: player lane.
REQ-009 Port jump, input, 1: player airborne; masks all collisions while high.
REQ-010 Port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-011 Port restart, input, 1: synchronous new-game request.
REQ-012 Port hit_pulse, output, 1: one-cycle pulse when a hazard costs a life.
REQ-013 Port got_powerup, output, 1: one-cycle pulse when a powerup is collected.
REQ-014 Port lives, output, LIFE_W = $clog2(MAX_LIVES+1): current life count.
REQ-015 Port invulnerable, output, 1: high while in state INVULN.
REQ-016 Port game_over, output, 1: high while in state DEAD.

Function
REQ-017 Slot i SHALL be in contact when all hold: active; lane equals lane; jump low; position strictly between W/4 and W, where W is POWERUP_WIDTH for POWERUP_OBSTACLE_TYPE and OBSTACLE_WIDTH otherwise.
REQ-018 Each slot SHALL keep a seen bit that is set in the cycle its contact first asserts and cleared in the cycle contact deasserts; only a contact rising edge per slot SHALL produce an event, so one pass produces exactly one event, and a second slot's contact is not masked by a first.
REQ-019 A cycle's events SHALL be new_hazard (at least one non-powerup rising edge) and new_powerup (at least one powerup rising edge); several edges of the same kind in one cycle SHALL count as one.
REQ-020 The FSM SHALL have states ALIVE, INVULN and DEAD, and all outputs SHALL be registered, appearing one cycle after the contact edge.
REQ-021 ALIVE with new_hazard: if the lives value after any same-cycle powerup increment is 1, lives SHALL become 0, the FSM SHALL go to DEAD and hit_pulse SHALL assert; otherwise lives SHALL decrement, hit_pulse SHALL assert, the FSM SHALL go to INVULN and the timer SHALL load INVULN_FRAMES.
REQ-022 INVULN SHALL ignore new_hazard (no pulse, no decrement, seen bits still update); the timer SHALL decrement on each frame_tick, and on the frame_tick that finds the timer at 1 the FSM SHALL go to ALIVE.
REQ-023 new_powerup in ALIVE or INVULN SHALL pulse got_powerup and increment lives, saturating at MAX_LIVES (got_powerup still pulses at saturation).
REQ-024 Simultaneous new_powerup and new_hazard in ALIVE SHALL apply the increment first, then the hazard rule; at lives = 1 the result is lives = 1 and state INVULN.
REQ-025 DEAD SHALL ignore all events and frame_tick, and is left only by reset or restart.
REQ-026 restart SHALL, in any state, load lives = START_LIVES, go to ALIVE, clear the timer and seen bits, and suppress both pulses that cycle; restart SHALL take priority over all events.

Reset
REQ-027 Asserting reset SHALL immediately set: state ALIVE; lives = START_LIVES; timer 0; all seen bits 0; hit_pulse, got_powerup, invulnerable and game_over 0.
REQ-028 Reset mid-INVULN or mid-DEAD SHALL fully abandon that state, and contacts still present when reset releases SHALL produce events on the first clock edge after release.

Structure
REQ-029 The obstacle struct, POWERUP_OBSTACLE_TYPE, POWERUP_WIDTH, OBSTACLE_WIDTH and a new collision_state_t enum (ALIVE, INVULN, DEAD) SHALL live in the shared data package.
REQ-030 Per-slot contact, seen-bit and edge logic SHALL be a sub-module obstacle_contact, instantiated NUM_OBSTACLES times via generate; the FSM, timer and lives logic stay in collision_manager.

Verification
REQ-031 Hazard in lane 1, player lane 1, position swept 0..OBSTACLE_WIDTH -> exactly one hit_pulse; lives 3 -> 2; invulnerable high for 120 frame_ticks, then low.
REQ-032 Two hazards entering contact 5 cycles apart in ALIVE -> first gives hit_pulse; second, arriving during INVULN, gives no pulse; lives = 2.
REQ-033 Lives 1 with hazard and powerup in the same cycle -> got_powerup and hit_pulse both pulse; lives = 1; invulnerable = 1; game_over = 0.
REQ-034 Lives 1 with hazard alone -> lives = 0 and game_over = 1; further hazards and powerups have no effect; restart -> lives = 3 and game_over = 0.
REQ-035 jump held high through a hazard's full pass -> no event; jump dropped while position = OBSTACLE_WIDTH-1 -> one hit_pulse.
REQ-036 Six powerups from lives 3 -> lives saturates at 5, six got_powerup pulses; reset asserted mid-INVULN -> asynchronous return to lives = 3 and all outputs 0.

Source files
------------

// File: rtl/collision_manager_pkg.sv
// rtl/collision_manager_pkg.sv - shared obstacle types, widths and collision FSM states
package collision_manager_pkg;

  localparam int LANE_W   = 2;
  localparam int SPRITE_W = 3;
  localparam int POS_W    = 8;

  localparam logic [SPRITE_W-1:0] POWERUP_OBSTACLE_TYPE = 3'd5;
  localparam int POWERUP_WIDTH  = 16;
  localparam int OBSTACLE_WIDTH = 32;

  typedef struct packed {
    logic                active;
    logic [LANE_W-1:0]   lane;
    logic [SPRITE_W-1:0] sprite_type;
    logic [POS_W-1:0]    position;
  } obstacle;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } collision_state_t;

  // Contact window is open strictly between a quarter of the sprite width and the full width.
  function automatic logic in_window(input logic [POS_W-1:0] position, input logic is_powerup);
    int width;
    width = is_powerup ? POWERUP_WIDTH : OBSTACLE_WIDTH;
    return (int'(position) > (width / 4)) && (int'(position) < width);
  endfunction

endpackage

// File: rtl/collision_manager_contact.sv
// rtl/collision_manager_contact.sv - per-slot contact detect with seen bit and rising-edge events
module obstacle_contact
  import collision_manager_pkg::*;
(
  input  logic              system_clock_in,
  input  logic              reset,
  input  logic              restart,
  input  obstacle           slot,
  input  logic [LANE_W-1:0] lane,
  input  logic              jump,
  output logic              hazard_edge,
  output logic              powerup_edge
);

  logic is_powerup;
  logic contact;
  logic seen;
  logic rising;

  assign is_powerup = (slot.sprite_type == POWERUP_OBSTACLE_TYPE);
  assign contact    = slot.active && (slot.lane == lane) && !jump
                      && in_window(slot.position, is_powerup);
  assign rising       = contact && !seen;
  assign hazard_edge  = rising && !is_powerup;
  assign powerup_edge = rising && is_powerup;

  // Seen bit tracks contact so a whole pass through the window yields a single event.
  always_ff @(posedge system_clock_in or posedge reset) begin
    if (reset) begin
      seen <= 1'b0;
    end else if (restart) begin
      seen <= 1'b0;
    end else begin
      seen <= contact;
    end
  end

endmodule

// File: rtl/collision_manager.sv
// rtl/collision_manager.sv - collision events, lives and invulnerability FSM
module collision_manager
  import collision_manager_pkg::*;
#(
  parameter  int NUM_OBSTACLES = 10,
  parameter  int START_LIVES   = 3,
  parameter  int MAX_LIVES     = 5,
  parameter  int INVULN_FRAMES = 120,
  localparam int LIFE_W        = $clog2(MAX_LIVES + 1)
) (
  input  logic                     system_clock_in,
  input  logic                     reset,
  input  obstacle [NUM_OBSTACLES-1:0] obstacles,
  input  logic [LANE_W-1:0]        lane,
  input  logic                     jump,
  input  logic                     frame_tick,
  input  logic                     restart,
  output logic                     hit_pulse,
  output logic                     got_powerup,
  output logic [LIFE_W-1:0]        lives,
  output logic                     invulnerable,
  output logic                     game_over
);

  localparam int TIMER_W = $clog2(INVULN_FRAMES + 1);

  logic [NUM_OBSTACLES-1:0] hazard_edges;
  logic [NUM_OBSTACLES-1:0] powerup_edges;
  logic                     new_hazard;
  logic                     new_powerup;

  collision_state_t    state_q, state_n;
  logic [LIFE_W-1:0]   lives_q, lives_n, lives_inc;
  logic [TIMER_W-1:0]  timer_q, timer_n;
  logic                hit_q, hit_n;
  logic                pw_q, pw_n;

  for (genvar i = 0; i < NUM_OBSTACLES; i++) begin : g_slot
    obstacle_contact u_contact (
      .system_clock_in (system_clock_in),
      .reset           (reset),
      .restart         (restart),
      .slot            (obstacles[i]),
      .lane            (lane),
      .jump            (jump),
      .hazard_edge     (hazard_edges[i]),
      .powerup_edge    (powerup_edges[i])
    );
  end

  assign new_hazard  = |hazard_edges;
  assign new_powerup = |powerup_edges;

  // State, lives, timer and pulse registers.
  always_ff @(posedge system_clock_in or posedge reset) begin
    if (reset) begin
      state_q <= ALIVE;
      lives_q <= LIFE_W'(START_LIVES);
      timer_q <= '0;
      hit_q   <= 1'b0;
      pw_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      lives_q <= lives_n;
      timer_q <= timer_n;
      hit_q   <= hit_n;
      pw_q    <= pw_n;
    end
  end

  // Next-state: restart wins; powerup increment is applied before the hazard rule.
  always_comb begin
    state_n   = state_q;
    lives_n   = lives_q;
    timer_n   = timer_q;
    hit_n     = 1'b0;
    pw_n      = 1'b0;
    lives_inc = lives_q;
    if (new_powerup) begin
      lives_inc = (lives_q >= LIFE_W'(MAX_LIVES)) ? LIFE_W'(MAX_LIVES) : lives_q + 1'b1;
    end

    if (restart) begin
      state_n = ALIVE;
      lives_n = LIFE_W'(START_LIVES);
      timer_n = '0;
    end else begin
      case (state_q)
        ALIVE: begin
          pw_n    = new_powerup;
          lives_n = lives_inc;
          if (new_hazard) begin
            hit_n = 1'b1;
            if (lives_inc <= LIFE_W'(1)) begin
              lives_n = '0;
              state_n = DEAD;
            end else begin
              lives_n = lives_inc - 1'b1;
              state_n = INVULN;
              timer_n = TIMER_W'(INVULN_FRAMES);
            end
          end
        end
        INVULN: begin
          pw_n    = new_powerup;
          lives_n = lives_inc;
          if (frame_tick) begin
            if (timer_q <= TIMER_W'(1)) begin
              timer_n = '0;
              state_n = ALIVE;
            end else begin
              timer_n = timer_q - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign hit_pulse    = hit_q;
  assign got_powerup  = pw_q;
  assign lives        = lives_q;
  assign invulnerable = (state_q == INVULN);
  assign game_over    = (state_q == DEAD);

endmodule

// File: tb/tb_collision_manager.sv
// tb/tb_collision_manager.sv - scoreboard bench for collision_manager
module tb_collision_manager;
  import collision_manager_pkg::*;

  localparam int N = 10;

  logic            clk = 1'b0;
  logic            reset;
  obstacle [N-1:0] obs;
  logic [1:0]      lane;
  logic            jump;
  logic            frame_tick;
  logic            restart;
  logic            hit_pulse;
  logic            got_powerup;
  logic [2:0]      lives;
  logic            invulnerable;
  logic            game_over;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  collision_manager dut (
    .system_clock_in (clk),
    .reset           (reset),
    .obstacles       (obs),
    .lane            (lane),
    .jump            (jump),
    .frame_tick      (frame_tick),
    .restart         (restart),
    .hit_pulse       (hit_pulse),
    .got_powerup     (got_powerup),
    .lives           (lives),
    .invulnerable    (invulnerable),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected output snapshot {hit, powerup, lives, invulnerable, game_over} for the next pulse.
  task automatic expect_event(input string tag, input bit h, input bit p, input int l,
                              input bit inv, input bit go);
    exp_q.push_back({h, p, 3'(l), inv, go});
    tag_q.push_back(tag);
  endtask

  // Every pulse cycle must match the oldest expectation; stray pulses are errors.
  always @(negedge clk) begin
    logic [6:0] seen_v;
    if (hit_pulse || got_powerup) begin
      seen_v = {hit_pulse, got_powerup, lives, invulnerable, game_over};
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(seen_v), 32'd0);
      end else begin
        check(tag_q.pop_front(), 32'(seen_v), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic set_slot(input int idx, input logic [2:0] kind, input logic [1:0] ln,
                          input logic [7:0] pos);
    obs[idx].active      = 1'b1;
    obs[idx].lane        = ln;
    obs[idx].sprite_type = kind;
    obs[idx].position    = pos;
  endtask

  task automatic do_restart();
    obs     = '0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    check("restart_lives", lives, 3);
    check("restart_state", {invulnerable, game_over}, 0);
  endtask

  task automatic hit_to(input int lv);
    set_slot(0, 3'd0, 2'd1, 8'd20);
    expect_event("hit_to", 1, 0, lv, 1, 0);
    tick();
    tick();
    obs[0].active = 1'b0;
    tick();
    frames(120);
    check("hit_to_alive", invulnerable, 0);
  endtask

  initial begin
    reset      = 1'b1;
    obs        = '0;
    lane       = 2'd1;
    jump       = 1'b0;
    frame_tick = 1'b0;
    restart    = 1'b0;
    repeat (3) tick();
    check("reset_lives", lives, 3);
    check("reset_hit", hit_pulse, 0);
    check("reset_pw", got_powerup, 0);
    check("reset_inv", invulnerable, 0);
    check("reset_go", game_over, 0);
    reset = 1'b0;
    tick();

    // Full sweep of a hazard: contact opens at position 9, closes at 32.
    set_slot(0, 3'd0, 2'd1, 8'd0);
    for (int p = 0; p <= 32; p++) begin
      obs[0].position = 8'(p);
      if (p == 9) expect_event("sweep_hit", 1, 0, 2, 1, 0);
      tick();
    end
    obs[0].active = 1'b0;
    tick();
    check("sweep_single", exp_q.size(), 0);
    check("sweep_lives", lives, 2);
    frames(119);
    check("inv_at_119", invulnerable, 1);
    frames(1);
    check("inv_at_120", invulnerable, 0);

    // Hazard in another lane never touches the player.
    set_slot(0, 3'd0, 2'd2, 8'd20);
    repeat (3) tick();
    obs = '0;
    tick();
    check("wrong_lane_lives", lives, 2);

    // Second hazard arriving during invulnerability is ignored.
    do_restart();
    set_slot(0, 3'd0, 2'd1, 8'd20);
    expect_event("first_hazard", 1, 0, 2, 1, 0);
    repeat (5) tick();
    set_slot(1, 3'd0, 2'd1, 8'd20);
    repeat (3) tick();
    check("two_hazard_lives", lives, 2);
    check("two_hazard_inv", invulnerable, 1);
    check("two_hazard_drained", exp_q.size(), 0);
    obs = '0;

    // Lives 1 with simultaneous hazard and powerup survives.
    do_restart();
    hit_to(2);
    hit_to(1);
    check("at_one", lives, 1);
    set_slot(0, 3'd0, 2'd1, 8'd20);
    set_slot(1, POWERUP_OBSTACLE_TYPE, 2'd1, 8'd10);
    expect_event("both_at_one", 1, 1, 1, 1, 0);
    tick();
    tick();
    obs = '0;
    tick();
    check("both_lives", lives, 1);
    check("both_inv", invulnerable, 1);
    check("both_go", game_over, 0);

    // Lives 1 with hazard alone dies; DEAD ignores everything until restart.
    do_restart();
    hit_to(2);
    hit_to(1);
    set_slot(0, 3'd0, 2'd1, 8'd20);
    expect_event("death", 1, 0, 0, 0, 1);
    tick();
    tick();
    obs = '0;
    tick();
    set_slot(0, 3'd0, 2'd1, 8'd20);
    set_slot(1, POWERUP_OBSTACLE_TYPE, 2'd1, 8'd10);
    tick();
    tick();
    obs = '0;
    frames(5);
    check("dead_lives", lives, 0);
    check("dead_go", game_over, 1);
    check("dead_inv", invulnerable, 0);
    do_restart();

    // Jump masks a full pass; dropping jump at the last window position hits.
    jump = 1'b1;
    set_slot(0, 3'd0, 2'd1, 8'd0);
    for (int p = 0; p <= 40; p++) begin
      obs[0].position = 8'(p);
      tick();
    end
    obs = '0;
    tick();
    check("jump_masked", lives, 3);
    set_slot(0, 3'd0, 2'd1, 8'd0);
    for (int p = 0; p <= 31; p++) begin
      obs[0].position = 8'(p);
      if (p == 31) begin
        jump = 1'b0;
        expect_event("jump_drop", 1, 0, 2, 1, 0);
      end
      tick();
    end
    obs = '0;
    tick();
    check("jump_drop_lives", lives, 2);

    // Six powerups saturate at 5, each still pulsing.
    do_restart();
    for (int k = 0; k < 6; k++) begin
      set_slot(1, POWERUP_OBSTACLE_TYPE, 2'd1, 8'd10);
      expect_event("powerup", 0, 1, (4 + k > 5) ? 5 : 4 + k, 0, 0);
      tick();
      obs[1].active = 1'b0;
      tick();
    end
    check("sat_lives", lives, 5);

    // Asynchronous reset mid-INVULN with the hazard still in contact.
    set_slot(0, 3'd0, 2'd1, 8'd20);
    expect_event("pre_reset_hit", 1, 0, 4, 1, 0);
    tick();
    tick();
    check("pre_reset_inv", invulnerable, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_lives", lives, 3);
    check("async_inv", invulnerable, 0);
    check("async_go", game_over, 0);
    check("async_pulses", {hit_pulse, got_powerup}, 0);
    tick();
    tick();
    expect_event("post_reset_hit", 1, 0, 2, 1, 0);
    reset = 1'b0;
    tick();
    tick();
    check("post_reset_lives", lives, 2);
    obs = '0;
    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
